rename_free_list: RTL and testbench

Parametrised physical-register free list for the rename stage, with branch checkpoints. It grants up to ALLOC_PORTS physical registers per cycle, all-or-nothing, and accepts up to FREE_PORTS commit-time releases per cycle. It keeps NUM_CKPT snapshots of the free mask so a mispredicted branch can restore allocation state in one cycle. It sits between the decode/rename allocator and the ROB commit path.

---
 rtl/core_pkg.sv | 27 ++
 rtl/free_list_pick.sv | 37 +++
 rtl/rename_free_list.sv | 150 +++++++++++++++
 tb/tb_rename_free_list.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the rename-stage physical register free list.
// Holds the default register-file sizing, the physical tag and checkpoint id
// types, and the popcount helper used for free_count and request counting.
package core_pkg;

  localparam int DEF_PREGS     = 48;
  localparam int DEF_ARCH_REGS = 32;
  localparam int DEF_NUM_CKPT  = 4;
  localparam int DEF_PREG_W    = $clog2(DEF_PREGS);
  localparam int DEF_CKPT_W    = $clog2(DEF_NUM_CKPT);

  // Widest vector popcount accepts; callers zero-extend into it.
  localparam int POPCNT_MAX = 256;

  typedef logic [DEF_PREG_W-1:0] preg_t;
  typedef logic [DEF_CKPT_W-1:0] ckpt_id_t;

  function automatic int unsigned popcount(input logic [POPCNT_MAX-1:0] vec);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < POPCNT_MAX; i++) begin
      if (vec[i]) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/free_list_pick.sv
// Combinational k-th-lowest-set-bit finder.
// Ports:
//   mask  : candidate bit vector (1 = available)
//   k     : zero-based rank of the set bit wanted
//   idx   : index of that set bit (0 when not found)
//   found : mask holds at least k+1 set bits
module free_list_pick
  import core_pkg::*;
#(
  parameter int N  = DEF_PREGS,
  parameter int KW = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [KW-1:0] k,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Walk upward counting set bits; the first set bit whose rank equals k wins.
  always_comb begin
    int seen;
    idx   = '0;
    found = 1'b0;
    seen  = 0;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        if (!found && (seen == int'(k))) begin
          idx   = IW'(i);
          found = 1'b1;
        end
        seen++;
      end
    end
  end

endmodule

// File: rtl/rename_free_list.sv
// Physical register free list with branch checkpoints.
// Grants up to ALLOC_PORTS registers per cycle (all-or-nothing, lowest tag
// first), accepts up to FREE_PORTS commit releases per cycle, and keeps
// NUM_CKPT snapshots of the free mask for single-cycle mispredict recovery.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   alloc_req/grant/phys : allocation lanes; phys valid when req && grant
//   free_en/free_phys    : release lanes
//   ckpt_take/restore/id : snapshot or restore slot ckpt_id
//   free_count           : registered number of free tags
//   err_double_free      : sticky double/out-of-range free flag
module rename_free_list
  import core_pkg::*;
#(
  parameter int PHYS_REGS   = DEF_PREGS,
  parameter int ARCH_REGS   = DEF_ARCH_REGS,
  parameter int ALLOC_PORTS = 2,
  parameter int FREE_PORTS  = 2,
  parameter int NUM_CKPT    = DEF_NUM_CKPT,
  parameter int PREG_W      = $clog2(PHYS_REGS),
  parameter int CKPT_W      = $clog2(NUM_CKPT)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [ALLOC_PORTS-1:0]              alloc_req,
  output logic                                alloc_grant,
  output logic [ALLOC_PORTS-1:0][PREG_W-1:0]  alloc_phys,
  input  logic [FREE_PORTS-1:0]               free_en,
  input  logic [FREE_PORTS-1:0][PREG_W-1:0]   free_phys,
  input  logic                                ckpt_take,
  input  logic                                ckpt_restore,
  input  logic [CKPT_W-1:0]                   ckpt_id,
  output logic [PREG_W:0]                     free_count,
  output logic                                err_double_free
);

  localparam int KW = $clog2(ALLOC_PORTS + 1);
  localparam logic [PHYS_REGS-1:0] INIT_MASK  = {PHYS_REGS{1'b1}} << ARCH_REGS;
  localparam logic [PREG_W:0]      INIT_COUNT = (PREG_W+1)'(PHYS_REGS - ARCH_REGS);

  logic [PHYS_REGS-1:0] free_mask_q, free_mask_d;
  logic [PHYS_REGS-1:0] ckpt_mask_q [NUM_CKPT];
  logic [PHYS_REGS-1:0] ckpt_mask_d [NUM_CKPT];
  logic [PREG_W:0]      free_count_q, free_count_d;
  logic                 err_q, err_d;

  logic [KW-1:0]                        lane_k [ALLOC_PORTS];
  logic [ALLOC_PORTS-1:0][PREG_W-1:0]   pick_idx;
  logic [ALLOC_PORTS-1:0]               pick_found;
  logic [PREG_W:0]                      req_count;
  logic [PHYS_REGS-1:0]                 granted_bits;
  logic [PHYS_REGS-1:0]                 released_bits;
  logic                                 err_now;

  // Sparse lanes: each requesting lane takes the next free tag in rank order,
  // so its rank is the number of requesting lanes below it.
  always_comb begin
    int below;
    below = 0;
    for (int a = 0; a < ALLOC_PORTS; a++) begin
      lane_k[a] = KW'(below);
      if (alloc_req[a]) below++;
    end
  end

  for (genvar a = 0; a < ALLOC_PORTS; a++) begin : g_pick
    free_list_pick #(
      .N  (PHYS_REGS),
      .KW (KW),
      .IW (PREG_W)
    ) u_pick (
      .mask  (free_mask_q),
      .k     (lane_k[a]),
      .idx   (pick_idx[a]),
      .found (pick_found[a])
    );
  end

  assign alloc_phys      = pick_idx;
  assign free_count      = free_count_q;
  assign err_double_free = err_q;

  // Grant decision uses only registered state, so this cycle's frees never
  // help an allocation until the next cycle.
  always_comb begin
    req_count   = (PREG_W+1)'(popcount(POPCNT_MAX'(alloc_req)));
    alloc_grant = !reset && !ckpt_restore && (req_count <= free_count_q);
  end

  // Release decode and error detection. A tag already free, or freed twice in
  // the same cycle, or beyond the register file, flags the sticky error.
  always_comb begin
    granted_bits  = '0;
    released_bits = '0;
    err_now       = 1'b0;
    if (alloc_grant) begin
      for (int a = 0; a < ALLOC_PORTS; a++) begin
        if (alloc_req[a] && pick_found[a]) granted_bits[pick_idx[a]] = 1'b1;
      end
    end
    for (int f = 0; f < FREE_PORTS; f++) begin
      if (free_en[f]) begin
        if (int'(free_phys[f]) >= PHYS_REGS) begin
          err_now = 1'b1;
        end else begin
          if (free_mask_q[free_phys[f]] || released_bits[free_phys[f]]) err_now = 1'b1;
          released_bits[free_phys[f]] = 1'b1;
        end
      end
    end
  end

  // Next-state mask and checkpoints. Releases are folded into every slot so a
  // later restore never resurrects a committed register as in-use. Restore
  // wins over take and leaves the restored slot itself unchanged.
  always_comb begin
    if (ckpt_restore) begin
      free_mask_d = ckpt_mask_q[ckpt_id] | released_bits;
    end else begin
      free_mask_d = (free_mask_q & ~granted_bits) | released_bits;
    end
    for (int c = 0; c < NUM_CKPT; c++) begin
      ckpt_mask_d[c] = ckpt_mask_q[c] | released_bits;
    end
    if (ckpt_take && !ckpt_restore) begin
      ckpt_mask_d[ckpt_id] = free_mask_d;
    end
    free_count_d = (PREG_W+1)'(popcount(POPCNT_MAX'(free_mask_d)));
    err_d        = err_q | err_now;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      free_mask_q  <= INIT_MASK;
      for (int c = 0; c < NUM_CKPT; c++) begin
        ckpt_mask_q[c] <= INIT_MASK;
      end
      free_count_q <= INIT_COUNT;
      err_q        <= 1'b0;
    end else begin
      free_mask_q  <= free_mask_d;
      for (int c = 0; c < NUM_CKPT; c++) begin
        ckpt_mask_q[c] <= ckpt_mask_d[c];
      end
      free_count_q <= free_count_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_rename_free_list.sv
// Self-checking bench for rename_free_list: directed scenarios followed by
// randomized traffic, all checked against a set-based reference model.
module tb_rename_free_list;

  localparam int PHYS_REGS   = 48;
  localparam int ARCH_REGS   = 32;
  localparam int ALLOC_PORTS = 2;
  localparam int FREE_PORTS  = 2;
  localparam int NUM_CKPT    = 4;
  localparam int PREG_W      = 6;
  localparam int CKPT_W      = 2;

  logic                                clk = 1'b0;
  logic                                reset = 1'b0;
  logic [ALLOC_PORTS-1:0]              alloc_req = '0;
  logic                                alloc_grant;
  logic [ALLOC_PORTS-1:0][PREG_W-1:0]  alloc_phys;
  logic [FREE_PORTS-1:0]               free_en = '0;
  logic [FREE_PORTS-1:0][PREG_W-1:0]   free_phys = '0;
  logic                                ckpt_take = 1'b0;
  logic                                ckpt_restore = 1'b0;
  logic [CKPT_W-1:0]                   ckpt_id = '0;
  logic [PREG_W:0]                     free_count;
  logic                                err_double_free;

  rename_free_list #(
    .PHYS_REGS   (PHYS_REGS),
    .ARCH_REGS   (ARCH_REGS),
    .ALLOC_PORTS (ALLOC_PORTS),
    .FREE_PORTS  (FREE_PORTS),
    .NUM_CKPT    (NUM_CKPT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .alloc_req       (alloc_req),
    .alloc_grant     (alloc_grant),
    .alloc_phys      (alloc_phys),
    .free_en         (free_en),
    .free_phys       (free_phys),
    .ckpt_take       (ckpt_take),
    .ckpt_restore    (ckpt_restore),
    .ckpt_id         (ckpt_id),
    .free_count      (free_count),
    .err_double_free (err_double_free)
  );

  always #5 clk = ~clk;

  // Reference model: set of free tags, snapshot sets, sticky error.
  bit m_free [PHYS_REGS];
  bit m_ckpt [NUM_CKPT][PHYS_REGS];
  bit m_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic obs_grant;
  int   obs_phys [ALLOC_PORTS];

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < PHYS_REGS; i++) if (m_free[i]) n++;
    return n;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < PHYS_REGS; i++) begin
      m_free[i] = (i >= ARCH_REGS);
      for (int c = 0; c < NUM_CKPT; c++) m_ckpt[c][i] = (i >= ARCH_REGS);
    end
    m_err = 1'b0;
  endfunction

  // Prefer releasing a tag the model considers in use.
  function automatic int pick_used_tag();
    int start = $urandom_range(0, PHYS_REGS - 1);
    for (int j = 0; j < PHYS_REGS; j++) begin
      int t = (start + j) % PHYS_REGS;
      if (!m_free[t]) return t;
    end
    return start;
  endfunction

  task automatic do_reset();
    alloc_req    = '0;
    free_en      = '0;
    ckpt_take    = 1'b0;
    ckpt_restore = 1'b0;
    reset        = 1'b1;
    #1;
    check_output("reset_count", free_count, PHYS_REGS - ARCH_REGS);
    check_output("reset_err", err_double_free, 0);
    check_output("reset_grant", alloc_grant, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle, check the combinational grant/tags before the edge,
  // advance the model, then check the registered outputs after the edge.
  task automatic apply_stimulus(input logic [1:0] req, input logic [1:0] fen,
                                input int f0, input int f1, input logic take,
                                input logic restore, input int id);
    int nreq;
    int k;
    int tag;
    bit exp_grant;
    int free_list[$];
    bit rel [PHYS_REGS];
    bit nxt [PHYS_REGS];

    alloc_req    = req;
    free_en      = fen;
    free_phys[0] = PREG_W'(f0);
    free_phys[1] = PREG_W'(f1);
    ckpt_take    = take;
    ckpt_restore = restore;
    ckpt_id      = CKPT_W'(id);

    free_list = {};
    for (int i = 0; i < PHYS_REGS; i++) if (m_free[i]) free_list.push_back(i);
    nreq      = $countones(req);
    exp_grant = !restore && (nreq <= free_list.size());

    @(negedge clk);
    obs_grant = alloc_grant;
    for (int a = 0; a < ALLOC_PORTS; a++) obs_phys[a] = int'(alloc_phys[a]);
    check_output("grant", alloc_grant, exp_grant);
    k = 0;
    for (int a = 0; a < ALLOC_PORTS; a++) begin
      if (req[a]) begin
        if (exp_grant) check_output($sformatf("phys_lane%0d", a), alloc_phys[a], free_list[k]);
        k++;
      end
    end

    for (int i = 0; i < PHYS_REGS; i++) rel[i] = 1'b0;
    for (int f = 0; f < FREE_PORTS; f++) begin
      if (fen[f]) begin
        tag = (f == 0) ? f0 : f1;
        if (tag >= PHYS_REGS) begin
          m_err = 1'b1;
        end else begin
          if (m_free[tag] || rel[tag]) m_err = 1'b1;
          rel[tag] = 1'b1;
        end
      end
    end
    if (restore) begin
      for (int i = 0; i < PHYS_REGS; i++) nxt[i] = m_ckpt[id][i] | rel[i];
    end else begin
      for (int i = 0; i < PHYS_REGS; i++) nxt[i] = m_free[i];
      if (exp_grant) begin
        k = 0;
        for (int a = 0; a < ALLOC_PORTS; a++) begin
          if (req[a]) begin
            nxt[free_list[k]] = 1'b0;
            k++;
          end
        end
      end
      for (int i = 0; i < PHYS_REGS; i++) nxt[i] = nxt[i] | rel[i];
    end
    for (int c = 0; c < NUM_CKPT; c++)
      for (int i = 0; i < PHYS_REGS; i++) m_ckpt[c][i] = m_ckpt[c][i] | rel[i];
    if (take && !restore) m_ckpt[id] = nxt;
    m_free = nxt;

    @(posedge clk);
    #1;
    check_output("free_count", free_count, model_count());
    check_output("err_double_free", err_double_free, m_err);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    do_reset();

    // First allocations after reset come from the lowest unmapped tags.
    apply_stimulus(2'b11, 2'b00, 0, 0, 0, 0, 0);
    check_output("plan_first_p0", obs_phys[0], 32);
    check_output("plan_first_p1", obs_phys[1], 33);
    check_output("plan_count14", free_count, 14);
    apply_stimulus(2'b10, 2'b00, 0, 0, 0, 0, 0);
    check_output("plan_sparse_lane1", obs_phys[1], 34);

    // Drain to one free tag, then exercise the all-or-nothing rule.
    repeat (6) apply_stimulus(2'b11, 2'b00, 0, 0, 0, 0, 0);
    check_output("plan_count1", free_count, 1);
    apply_stimulus(2'b11, 2'b00, 0, 0, 0, 0, 0);
    check_output("plan_no_partial", obs_grant, 0);
    check_output("plan_still1", free_count, 1);
    apply_stimulus(2'b01, 2'b00, 0, 0, 0, 0, 0);
    check_output("plan_last_tag", obs_phys[0], 47);
    check_output("plan_empty", free_count, 0);

    // Same-cycle free cannot rescue an empty list.
    apply_stimulus(2'b01, 2'b01, 40, 0, 0, 0, 0);
    check_output("plan_empty_grant", obs_grant, 0);
    apply_stimulus(2'b01, 2'b00, 0, 0, 0, 0, 0);
    check_output("plan_refill_grant", obs_grant, 1);
    check_output("plan_refill_tag", obs_phys[0], 40);

    // Double free is sticky until reset.
    apply_stimulus(2'b00, 2'b01, 45, 0, 0, 0, 0);
    apply_stimulus(2'b00, 2'b01, 45, 0, 0, 0, 0);
    check_output("plan_double_free", err_double_free, 1);
    apply_stimulus(2'b00, 2'b00, 0, 0, 0, 0, 0);
    check_output("plan_err_sticky", err_double_free, 1);
    do_reset();
    apply_stimulus(2'b01, 2'b00, 0, 0, 0, 0, 0);
    check_output("plan_post_reset_tag", obs_phys[0], 32);
    do_reset();

    // Checkpoint taken alongside allocation, then restored.
    apply_stimulus(2'b11, 2'b00, 0, 0, 1, 0, 1);
    apply_stimulus(2'b11, 2'b00, 0, 0, 0, 0, 0);
    check_output("plan_ckpt_p0", obs_phys[0], 34);
    apply_stimulus(2'b11, 2'b00, 0, 0, 0, 1, 1);
    check_output("plan_restore_grant", obs_grant, 0);
    apply_stimulus(2'b11, 2'b00, 0, 0, 0, 0, 0);
    check_output("plan_reuse_p0", obs_phys[0], 34);
    check_output("plan_reuse_p1", obs_phys[1], 35);

    // A release after a snapshot survives a restore of that snapshot.
    apply_stimulus(2'b00, 2'b00, 0, 0, 1, 0, 0);
    apply_stimulus(2'b00, 2'b00, 0, 0, 0, 0, 0);
    apply_stimulus(2'b00, 2'b01, 5, 0, 0, 0, 0);
    apply_stimulus(2'b00, 2'b00, 0, 0, 0, 1, 0);
    check_output("plan_restore_count", free_count, 13);
    apply_stimulus(2'b01, 2'b00, 0, 0, 0, 0, 0);
    check_output("plan_restored_free5", obs_phys[0], 5);

    // Randomized traffic with periodic resets.
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ((cyc % 100) == 99) begin
        do_reset();
      end else begin
        int f0;
        int f1;
        int sel;
        sel = $urandom_range(0, 19);
        f0  = (sel < 15) ? pick_used_tag() :
              (sel < 18) ? $urandom_range(0, PHYS_REGS - 1) : $urandom_range(PHYS_REGS, 63);
        sel = $urandom_range(0, 19);
        f1  = (sel < 15) ? pick_used_tag() :
              (sel < 18) ? $urandom_range(0, PHYS_REGS - 1) : $urandom_range(PHYS_REGS, 63);
        apply_stimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), f0, f1,
                       ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                       $urandom_range(0, NUM_CKPT - 1));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
